l1_wb_cache: RTL and testbench
==============================

// Module: l1_wb_cache
// PURPOSE
//  Direct-mapped, write-back, write-allocate cache between the multicycle RV32I core's
//  word memory port (mem_*) and a 256-bit-line physical memory port (pmem_*).
//  The core keeps its request asserted until mem_resp. The cache returns hits in the
//  same cycle, and handles misses with an optional dirty writeback followed by a line fill.
// PARAMETERS
//  NUM_SETS  8  number of lines; power of 2, >=2. IDX=$clog2(NUM_SETS), TAG=27-IDX
// PORTS
//  clk              in   1    clock, all state updates on rising edge
//  rst_n            in   1    asynchronous active-low reset
//  mem_read         in   1    core read request (held until mem_resp)
//  mem_write        in   1    core write request (held until mem_resp)
//  mem_byte_enable  in   4    byte lanes for writes; ignored for reads
//  mem_address      in   32   byte address; [1:0] ignored, [4:2] word, [4+IDX:5] index
//  mem_wdata        in   32   write data
//  mem_resp         out  1    request complete this cycle
//  mem_rdata        out  32   read word, valid when mem_resp && mem_read
//  pmem_read        out  1    line fill request, held until pmem_resp
//  pmem_write       out  1    line writeback request, held until pmem_resp
//  pmem_address     out  32   line address, [4:0]=0
//  pmem_wdata       out  256  writeback line
//  pmem_rdata       in   256  fill line, valid with pmem_resp
//  pmem_resp        in   1    physical memory done (one-cycle pulse)
// BEHAVIOUR
//  Storage: per set valid, dirty, tag[TAG-1:0], data[255:0]. Word w lives in data[32w+:32].
//  Reset (async): state=IDLE, all valid=0, all dirty=0. Outputs mem_resp, pmem_read,
//   and pmem_write are 0. pmem_address and pmem_wdata are 0 while idle. Data and tag arrays are not reset.
//  req = mem_read|mem_write. If both are set, the request is a write; mem_rdata is don't-care.
//  hit = valid[idx] && tag[idx]==mem_address[31:5+IDX].
//  FSM states IDLE, WRITEBACK, ALLOCATE:
//   IDLE: on req&&hit, mem_resp=1 combinationally, in the same cycle.
//    On a read, mem_rdata = data[idx] word [4:2].
//    On a write, at the clock edge each enabled byte is merged into the word and dirty[idx] is set.
//    If the core holds the request an extra cycle, the repeated write is harmless.
//    On req&&!hit: go to WRITEBACK if valid&&dirty, else go to ALLOCATE. mem_resp stays 0.
//    With no req, stay in IDLE. pmem_resp is ignored in IDLE.
//   WRITEBACK: pmem_write=1, pmem_address={tag[idx],idx,5'b0}, pmem_wdata=data[idx].
//    Stay until pmem_resp. On pmem_resp: dirty[idx]=0, then go to ALLOCATE.
//   ALLOCATE: pmem_read=1, pmem_address={mem_address[31:5],5'b0}.
//    On pmem_resp: data=pmem_rdata, tag updated, valid=1, dirty=0, then go to IDLE.
//    The request is then served as a hit the following cycle.
//  Latency: hit=0 extra cycles; clean miss=fill+1; dirty miss=wb+fill+1.
//  pmem_read and pmem_write are never asserted together, and each is dropped in the cycle after pmem_resp.
//  mem_address must stay stable while a request is pending. If req drops mid-miss, the
//   current pmem transaction still completes, the fill is installed, and no mem_resp is issued.
//  Reset mid-miss: the FSM aborts immediately and pmem_* drop.
//   The line is left invalid, so the next access misses.
// TESTING
//  T1 cold read 0x48: pmem_read addr 0x40. Fill word2=0xDEADBEEF -> mem_resp with 0xDEADBEEF, 1 cycle after fill.
//  T2 read 0x4C after T1: mem_resp in the same cycle as the request; pmem_read/pmem_write stay 0.
//  T3 write 0x48 wdata 0x12345678, be=0011 -> resp 0 extra cycles; then read 0x48 returns 0xDEAD5678.
//  T4 read 0x148 (same index 2) after T3: pmem_write addr 0x40 with word2=0xDEAD5678,
//     then pmem_read addr 0x140, then mem_resp.
//  T5 read 0x248 after T4 (line clean): no pmem_write; only pmem_read addr 0x240.
//  T6 rst_n low while pmem_read high: pmem_read=0 immediately. Re-read 0x248 misses and refills.

Source files
------------

// File: rtl/l1_wb_cache_if.sv
// Core word port and physical line port of the L1 write-back cache.
// The master modport is the environment side; slave is the cache.
interface l1_wb_cache_if;
   logic         mem_read;
   logic         mem_write;
   logic [3:0]   mem_byte_enable;
   logic [31:0]  mem_address;
   logic [31:0]  mem_wdata;
   logic         mem_resp;
   logic [31:0]  mem_rdata;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   modport slave (
      input  mem_read, mem_write, mem_byte_enable,
      input  mem_address, mem_wdata,
      output mem_resp, mem_rdata,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output mem_read, mem_write, mem_byte_enable,
      output mem_address, mem_wdata,
      input  mem_resp, mem_rdata,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/l1_wb_cache.sv
// Direct-mapped write-back, write-allocate L1 cache.
// Hits answer in the same cycle; misses do writeback then fill.
module l1_wb_cache #(
   parameter int NUM_SETS = 8
) (
   input logic           clk,
   input logic           rst_n,
   l1_wb_cache_if.slave  bus
);
   localparam int IDX = $clog2(NUM_SETS);
   localparam int TAG = 27 - IDX;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE
   } state_e;

   state_e              state_q, state_d;
   logic [NUM_SETS-1:0] valid_q, valid_d;
   logic [NUM_SETS-1:0] dirty_q, dirty_d;
   logic [TAG-1:0]      tag_q [NUM_SETS];
   logic [255:0]        data_q [NUM_SETS];

   logic [IDX-1:0] idx;
   logic [TAG-1:0] tag_d;
   logic [2:0]     wsel;
   logic [7:0]     woff;
   logic           req;
   logic           hit;
   logic           line_we;
   logic           tag_we;
   logic [255:0]   line_d;
   logic [31:0]    word_cur;
   logic [31:0]    word_mrg;
   logic           unused_addr;

   assign idx         = bus.mem_address[4+IDX:5];
   assign tag_d       = bus.mem_address[31:5+IDX];
   assign wsel        = bus.mem_address[4:2];
   assign woff        = {wsel, 5'b0};
   assign unused_addr = ^bus.mem_address[1:0];
   assign req         = bus.mem_read | bus.mem_write;
   assign hit         = valid_q[idx] && (tag_q[idx] == tag_d);
   assign word_cur    = data_q[idx][woff +: 32];
   assign bus.mem_rdata = word_cur;

   always_comb begin
      word_mrg = word_cur;
      for (int b = 0; b < 4; b++) begin
         if (bus.mem_byte_enable[b]) begin
            word_mrg[8*b +: 8] = bus.mem_wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      valid_d          = valid_q;
      dirty_d          = dirty_q;
      line_we          = 1'b0;
      tag_we           = 1'b0;
      line_d           = data_q[idx];
      bus.mem_resp     = 1'b0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      unique case (state_q)
         IDLE: begin
            if (req && hit) begin
               bus.mem_resp = 1'b1;
               if (bus.mem_write) begin
                  line_we              = 1'b1;
                  line_d[woff +: 32]   = word_mrg;
                  dirty_d[idx]         = 1'b1;
               end
            end else if (req) begin
               if (valid_q[idx] && dirty_q[idx]) begin
                  state_d = WRITEBACK;
               end else begin
                  state_d = ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_q[idx], idx, 5'b0};
            bus.pmem_wdata   = data_q[idx];
            if (bus.pmem_resp) begin
               dirty_d[idx] = 1'b0;
               state_d      = ALLOCATE;
            end
         end
         ALLOCATE: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {bus.mem_address[31:5], 5'b0};
            if (bus.pmem_resp) begin
               line_we      = 1'b1;
               tag_we       = 1'b1;
               line_d       = bus.pmem_rdata;
               valid_d[idx] = 1'b1;
               dirty_d[idx] = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Line storage carries no reset; valid bits guard it.
   always_ff @(posedge clk) begin
      if (line_we) begin
         data_q[idx] <= line_d;
      end
      if (tag_we) begin
         tag_q[idx] <= tag_d;
      end
   end
endmodule

// File: tb/tb_l1_wb_cache.sv
// Randomized self-checking bench for l1_wb_cache against a
// flat-memory reference plus a set-occupancy model.
module tb_l1_wb_cache;
   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] line;
   } pm_t;

   logic clk;
   logic rst_n;
   l1_wb_cache_if bus ();

   l1_wb_cache #(.NUM_SETS(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc_n = 0;
   int last_resp_cyc = -10;
   int n_rd = 0;
   int n_wr = 0;
   bit no_resp = 0;
   logic [31:0]  last_rd_addr = '0;
   logic [31:0]  last_wr_addr = '0;
   logic [255:0] last_wr_line = '0;

   logic [255:0] back_m [logic [31:0]];
   logic [255:0] ref_m [logic [31:0]];
   bit           mv [8];
   bit           md [8];
   logic [31:0]  mt [8];
   pm_t          exp_q [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s", nm);
   endtask

   function automatic logic [255:0] init_line(input logic [31:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) begin
         l[32*w +: 32] = ((la | (32'(w) << 2)) * 32'h9E3779B1)
                         ^ 32'h5BD1E995;
      end
      return l;
   endfunction

   function automatic logic [255:0] get_back(input logic [31:0] la);
      if (back_m.exists(la)) return back_m[la];
      return init_line(la);
   endfunction

   function automatic logic [255:0] get_ref(input logic [31:0] la);
      if (ref_m.exists(la)) return ref_m[la];
      return init_line(la);
   endfunction

   // Physical memory: random latency, checks every transaction.
   initial begin : pmem_model
      bit           iswr;
      bit           abort;
      logic [31:0]  pa;
      logic [255:0] pw;
      pm_t          e;
      int           lat;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
            iswr  = bus.pmem_write;
            pa    = bus.pmem_address;
            pw    = bus.pmem_wdata;
            abort = 0;
            if (exp_q.size() == 0) begin
               fail("pmem unexpected transaction");
            end else begin
               e = exp_q.pop_front();
               chk("pmem kind", 256'(iswr), 256'(e.wr));
               chk("pmem addr", pa, e.addr);
               if (iswr) chk("pmem wdata", pw, e.line);
            end
            if (iswr) begin
               n_wr++;
               last_wr_addr = pa;
               last_wr_line = pw;
            end else begin
               n_rd++;
               last_rd_addr = pa;
            end
            lat = $urandom_range(0, 3);
            repeat (lat) begin
               @(negedge clk);
               if (!rst_n) abort = 1;
            end
            while (no_resp && rst_n) @(negedge clk);
            if (!rst_n) abort = 1;
            if (!abort) begin
               bus.pmem_resp = 1'b1;
               if (iswr) back_m[pa] = pw;
               else bus.pmem_rdata = get_back(pa);
               last_resp_cyc = cyc_n;
               @(negedge clk);
               bus.pmem_resp = 1'b0;
               chk("pmem drop after resp",
                   iswr ? bus.pmem_write : bus.pmem_read, 0);
            end
         end
      end
   end

   // Every-cycle protocol checks.
   always @(negedge clk) begin
      chk("pmem read/write exclusive",
          bus.pmem_read & bus.pmem_write, 0);
      if (!bus.pmem_read && !bus.pmem_write) begin
         chk("idle pmem_address", bus.pmem_address, 0);
         chk("idle pmem_wdata", bus.pmem_wdata, 0);
      end else begin
         chk("pmem_address align", bus.pmem_address[4:0], 0);
      end
      if (!(bus.mem_read | bus.mem_write)) begin
         chk("mem_resp without req", bus.mem_resp, 0);
      end
   end

   task automatic do_req(input bit wr, input bit rd,
                         input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input bit hold,
                         input string nm,
                         output logic [31:0] rdo, output int c);
      logic [31:0]  la;
      logic [255:0] line;
      logic [31:0]  exp_rd;
      logic [31:0]  word;
      int           s;
      int           w;
      bit           hit;
      bit           got;
      la  = a & 32'hFFFF_FFE0;
      s   = int'(a[7:5]);
      w   = int'(a[4:2]);
      hit = mv[s] && (mt[s] == la);
      if (!hit) begin
         if (mv[s] && md[s]) begin
            exp_q.push_back('{1'b1, mt[s], get_ref(mt[s])});
         end
         exp_q.push_back('{1'b0, la, '0});
         mv[s] = 1;
         md[s] = 0;
         mt[s] = la;
      end
      line   = get_ref(la);
      exp_rd = line[32*w +: 32];
      if (wr) begin
         word = exp_rd;
         for (int b = 0; b < 4; b++) begin
            if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
         end
         line[32*w +: 32] = word;
         ref_m[la] = line;
         md[s] = 1;
      end
      bus.mem_read        = rd;
      bus.mem_write       = wr;
      bus.mem_address     = a;
      bus.mem_byte_enable = be;
      bus.mem_wdata       = wd;
      c   = 0;
      got = 0;
      rdo = '0;
      while (c < 300) begin
         @(negedge clk);
         if (bus.mem_resp) begin
            got = 1;
            break;
         end
         c++;
      end
      if (!got) begin
         fail({nm, " timeout waiting mem_resp"});
      end else begin
         if (hit) chk({nm, " hit latency"}, c, 0);
         else chk({nm, " miss latency"}, cyc_n, last_resp_cyc + 1);
         chk({nm, " pmem traffic drained"}, exp_q.size(), 0);
         rdo = bus.mem_rdata;
         if (rd && !wr) chk({nm, " rdata"}, rdo, exp_rd);
      end
      @(posedge clk);
      #1;
      if (hold && got) begin
         @(negedge clk);
         chk({nm, " held req resp"}, bus.mem_resp, 1);
         if (rd && !wr) chk({nm, " held rdata"}, bus.mem_rdata, exp_rd);
         @(posedge clk);
         #1;
      end
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [255:0] line;
      logic [31:0]  rd;
      logic [31:0]  a;
      int           c;
      int           nrd0;
      int           nwr0;
      bit           wr;
      bit           rdq;
      rst_n               = 1'b0;
      bus.mem_read        = 1'b0;
      bus.mem_write       = 1'b0;
      bus.mem_byte_enable = '0;
      bus.mem_address     = '0;
      bus.mem_wdata       = '0;
      for (int i = 0; i < 8; i++) begin
         mv[i] = 0;
         md[i] = 0;
         mt[i] = '0;
      end
      #12;
      chk("reset mem_resp", bus.mem_resp, 0);
      chk("reset pmem_read", bus.pmem_read, 0);
      chk("reset pmem_write", bus.pmem_write, 0);
      chk("reset pmem_address", bus.pmem_address, 0);
      chk("reset pmem_wdata", bus.pmem_wdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      line = init_line(32'h40);
      line[95:64] = 32'hDEADBEEF;
      back_m[32'h40] = line;
      ref_m[32'h40]  = line;
      do_req(0, 1, 32'h48, 4'hF, 0, 0, "t1", rd, c);
      chk("t1 rdata literal", rd, 32'hDEADBEEF);
      chk("t1 fill addr", last_rd_addr, 32'h40);

      nrd0 = n_rd;
      nwr0 = n_wr;
      do_req(0, 1, 32'h4C, 4'hF, 0, 0, "t2", rd, c);
      chk("t2 same cycle", c, 0);
      chk("t2 no pmem_read", n_rd, nrd0);
      chk("t2 no pmem_write", n_wr, nwr0);

      do_req(1, 0, 32'h48, 4'b0011, 32'h12345678, 0, "t3w", rd, c);
      chk("t3 write same cycle", c, 0);
      do_req(0, 1, 32'h48, 4'hF, 0, 0, "t3r", rd, c);
      chk("t3 merged literal", rd, 32'hDEAD5678);

      do_req(0, 1, 32'h148, 4'hF, 0, 0, "t4", rd, c);
      chk("t4 writeback count", n_wr, nwr0 + 1);
      chk("t4 writeback addr", last_wr_addr, 32'h40);
      chk("t4 writeback word2", last_wr_line[95:64], 32'hDEAD5678);
      chk("t4 fill addr", last_rd_addr, 32'h140);

      nwr0 = n_wr;
      do_req(0, 1, 32'h248, 4'hF, 0, 0, "t5", rd, c);
      chk("t5 no writeback", n_wr, nwr0);
      chk("t5 fill addr", last_rd_addr, 32'h240);

      no_resp = 1;
      exp_q.push_back('{1'b0, 32'h340, '0});
      bus.mem_address     = 32'h348;
      bus.mem_byte_enable = 4'hF;
      bus.mem_read        = 1'b1;
      c = 0;
      while (!bus.pmem_read && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("t6 fill started", bus.pmem_read, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6 pmem_read async drop", bus.pmem_read, 0);
      chk("t6 pmem_address async drop", bus.pmem_address, 0);
      bus.mem_read = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mv[i] = 0;
         md[i] = 0;
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      no_resp = 0;
      @(posedge clk);
      #1;
      nrd0 = n_rd;
      do_req(0, 1, 32'h248, 4'hF, 0, 0, "t6 reread", rd, c);
      chk("t6 refill count", n_rd, nrd0 + 1);
      chk("t6 refill addr", last_rd_addr, 32'h240);

      for (int i = 0; i < 400; i++) begin
         a = 32'h1000 + 32'($urandom_range(0, 3)) * 256
             + 32'($urandom_range(0, 7)) * 32
             + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
         wr  = ($urandom_range(0, 1) == 1);
         rdq = wr ? ($urandom_range(0, 2) == 0) : 1'b1;
         do_req(wr, rdq, a, 4'($urandom), $urandom,
                ($urandom_range(0, 3) == 0), "rand", rd, c);
      end
      repeat (4) @(negedge clk);
      chk("final pmem queue empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
